// File: rtl/mult_job_arbiter.sv
// mult_job_arbiter: round-robin front end that time-shares one external
// multiply/popcount engine among NREQ requesters. It runs one job at a time,
// aborts a job whose engine never answers, and keeps job/error counters.
module mult_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*24-1:0] req_a1,
  input  logic [NREQ*24-1:0] req_a2,
  output logic [NREQ-1:0]    req_ready,
  output logic               eng_start,
  output logic [23:0]        eng_a1,
  output logic [23:0]        eng_a2,
  input  logic               eng_done,
  input  logic [31:0]        eng_w,
  input  logic [23:0]        eng_ones,
  input  logic               eng_ovf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_w,
  output logic [23:0]        rsp_ones,
  output logic               rsp_ovf,
  output logic               rsp_err,
  output logic               busy,
  output logic [15:0]        job_count,
  output logic [7:0]         err_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  // Timer only has to count WAIT cycles 0 .. TIMEOUT-1.
  localparam int              TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  RR_INIT    = IDW'(NREQ - 1);

  state_e         state_q, state_d;
  logic           run_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [23:0]    eng_a1_q, eng_a1_d, eng_a2_q, eng_a2_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_w_q, rsp_w_d;
  logic [23:0]    rsp_ones_q, rsp_ones_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_err_q, rsp_err_d;
  logic [15:0]    job_count_q, job_count_d;
  logic [7:0]     err_count_q, err_count_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           take_job;
  logic           timer_expired;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    // NOTE: every signal assigned in a comb block gets a default first, so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // run_q holds off grants for the first cycle after reset release, so
  // req_ready is guaranteed low throughout reset.
  assign take_job      = (state_q == S_IDLE) && run_q && grant_found;
  assign timer_expired = (timer_q == TIMER_LAST);

  // State register and reset-release qualifier.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      // NOTE: flops are updated with non-blocking assignments so every register samples pre-edge values.
      state_q <= S_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state logic; eng_done wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (take_job)                    state_d = S_ISSUE;
      S_ISSUE:                                  state_d = S_WAIT;
      S_WAIT:  if (eng_done || timer_expired)   state_d = S_RESP;
      S_RESP:  if (rsp_ready)                   state_d = S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // Moore/Mealy outputs decoded from the current state.
  always_comb begin
    req_ready = '0;
    if (take_job) req_ready = NREQ'(1) << grant_idx;
    eng_start = (state_q == S_ISSUE);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next values: operand capture, result capture, timer, counters.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    eng_a1_d    = eng_a1_q;
    eng_a2_d    = eng_a2_q;
    rsp_id_d    = rsp_id_q;
    rsp_w_d     = rsp_w_q;
    rsp_ones_d  = rsp_ones_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    job_count_d = job_count_q;
    err_count_d = err_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (take_job) begin
          eng_a1_d = req_a1[int'(grant_idx)*24 +: 24];
          eng_a2_d = req_a2[int'(grant_idx)*24 +: 24];
          rsp_id_d = grant_idx;
          rr_ptr_d = grant_idx;
        end
      end
      S_ISSUE: timer_d = '0;
      S_WAIT: begin
        if (eng_done) begin
          rsp_w_d    = eng_w;
          rsp_ones_d = eng_ones;
          rsp_ovf_d  = eng_ovf;
          rsp_err_d  = 1'b0;
        end else if (timer_expired) begin
          rsp_w_d    = '0;
          rsp_ones_d = '0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!rsp_err_q)                  job_count_d = job_count_q + 16'd1;
          else if (err_count_q != 8'hFF)   err_count_d = err_count_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rr_ptr_q    <= RR_INIT;
      timer_q     <= '0;
      eng_a1_q    <= '0;
      eng_a2_q    <= '0;
      rsp_id_q    <= '0;
      rsp_w_q     <= '0;
      rsp_ones_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      job_count_q <= '0;
      err_count_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      eng_a1_q    <= eng_a1_d;
      eng_a2_q    <= eng_a2_d;
      rsp_id_q    <= rsp_id_d;
      rsp_w_q     <= rsp_w_d;
      rsp_ones_q  <= rsp_ones_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      job_count_q <= job_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign eng_a1    = eng_a1_q;
  assign eng_a2    = eng_a2_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_w     = rsp_w_q;
  assign rsp_ones  = rsp_ones_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign job_count = job_count_q;
  assign err_count = err_count_q;

endmodule

// File: doc/mult_job_arbiter.md
Name: mult_job_arbiter

Overview:
- Round-robin scheduler that shares one external multiply/popcount engine (24x24 multiply, low-32 result W, ones count L, overflow flag) among NREQ requesters.
- Accepts one job at a time, sequences the engine with a start/done handshake, and enforces a completion timeout.
- Returns each result on a shared response channel tagged with the requester ID.
- Keeps job and error counters for status readout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID; equals clog2(NREQ).
- TIMEOUT, 64, maximum cycles in WAIT before a job is aborted (>=2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester job request; held high until accepted.
- req_a1  in  NREQ*24  operand A1, requester i at bits [24i+23:24i].
- req_a2  in  NREQ*24  operand A2, same packing.
- req_ready  out  NREQ  one-hot accept pulse, one cycle.
- eng_start  out  1  engine start pulse, one cycle.
- eng_a1  out  24  operand to engine.
- eng_a2  out  24  operand to engine.
- eng_done  in  1  engine completion pulse.
- eng_w  in  32  engine result low 32 bits; valid with eng_done.
- eng_ones  in  24  engine ones count; valid with eng_done.
- eng_ovf  in  1  engine overflow flag (product bits 47:32 nonzero); valid with eng_done.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  IDW  requester index of the response.
- rsp_w  out  32  result W.
- rsp_ones  out  24  result L.
- rsp_ovf  out  1  overflow flag.
- rsp_err  out  1  job aborted on timeout.
- busy  out  1  high whenever state is not IDLE.
- job_count  out  16  completed successful jobs.
- err_count  out  8  timed-out jobs.

Behaviour:
- Reset (async, n_reset=0):
  - state=IDLE.
  - All outputs 0, including the rsp_* fields, counters and operand registers.
  - rr_ptr=NREQ-1, so requester 0 is served first after reset.
  - Reset mid-job abandons the job with no response; any later eng_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_valid bit is high:
  - Grant the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Latch that requester's a1/a2 into eng_a1/eng_a2 and latch grant into rsp_id.
  - Pulse req_ready[grant] this cycle, set rr_ptr=grant, go to ISSUE.
  - Requests are sampled only in IDLE; req_ready is 0 in every other state.
- ISSUE: eng_start=1 for exactly this cycle; clear timer; go to WAIT.
- WAIT:
  - eng_a1/eng_a2 held stable.
  - If eng_done=1: register eng_w, eng_ones and eng_ovf into rsp_*, set rsp_err=0, go to RESP.
  - Else timer++; when timer reaches TIMEOUT-1 with no done: set rsp_w=0, rsp_ones=0, rsp_ovf=0, rsp_err=1, go to RESP.
  - eng_done arriving on the same cycle as the timeout takes priority: the job completes normally.
- RESP:
  - rsp_valid=1, with all rsp_* fields stable, until rsp_ready=1 is sampled.
  - On that cycle: rsp_valid drops the next cycle; go to IDLE.
  - Counters: job_count++ if rsp_err=0, else err_count++.
- Minimum latency with an immediate eng_done and rsp_ready held high: req_ready at cycle 0, eng_start at cycle 1, rsp_valid at cycle 3, next grant possible at cycle 4.
- eng_done outside WAIT is ignored.
- job_count wraps 0xFFFF->0x0000.
- err_count saturates at 0xFF.
- busy = (state != IDLE).

Test Plan:
- After reset, req_valid=0001, a1=3, a2=5, engine returns w=15, ones=4, ovf=0 → req_ready=0001, one eng_start pulse, rsp_id=0, rsp_w=0x0000000F, rsp_ones=4, rsp_err=0, job_count=1.
- Requesters 0 and 2 both requesting continuously over 4 jobs → grant order 0,2,0,2; each req_ready one cycle; no starvation.
- a1=a2=0xFFFFFF, engine returns w=0xFE000001, ones=8, ovf=1 → rsp_w=0xFE000001, rsp_ones=8, rsp_ovf=1, rsp_err=0.
- Engine never asserts done → after TIMEOUT cycles in WAIT: rsp_valid, rsp_err=1, rsp_w=0; err_count=1, job_count unchanged; a late eng_done is ignored.
- rsp_ready held low 10 cycles while req_valid=1111 → rsp fields stable, no req_ready and no eng_start; the next grant follows the RR order after release.
- n_reset pulsed during WAIT → all outputs 0 immediately, no response emitted; the next grant goes to requester 0.
